// File: rtl/spi_master_if.sv
// Host-side request/response bundle for spi_master.
// The requester uses the master modport, the SPI engine the slave modport.
interface spi_master_if;
  logic       start;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output data_out
  );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master, MSB first, s_clk half-period of CLK_DIV clocks.
// Define SPI_MASTER_BURST_EN to chain bytes without releasing slave_sel.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.slave  host,
  input  logic         miso,
  output logic         s_clk,
  output logic         mosi,
  output logic         slave_sel
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEAD = 3'd1;
  localparam logic [2:0] HIGH = 3'd2;
  localparam logic [2:0] LOW  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] div;
  logic [3:0] bits;
  logic [7:0] tx;
  logic [7:0] rx;
  logic [7:0] rx_out;
  logic       expired;
  logic       take;

  assign expired = (div == 8'd0);

`ifdef SPI_MASTER_BURST_EN
  assign take = host.start && (state == IDLE || state == DONE);
`else
  assign take = host.start && (state == IDLE);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = LEAD;
      LEAD: if (expired) state_nxt = HIGH;
      HIGH: if (expired) state_nxt = LOW;
      LOW: begin
        if (expired) begin
          state_nxt = (bits < 4'd8) ? HIGH : DONE;
        end
      end
      DONE: state_nxt = take ? LEAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifts happen on the edge that enters HIGH / LOW, i.e. with s_clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      div    <= 8'd0;
      bits   <= 4'd0;
      tx     <= 8'd0;
      rx     <= 8'd0;
      rx_out <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        div <= RELOAD;
      end else if (div != 8'd0) begin
        div <= div - 8'd1;
      end
      if (take) begin
        tx   <= host.data_in;
        bits <= 4'd0;
      end
      if (state_nxt == HIGH && state != HIGH) begin
        rx <= {rx[6:0], miso};
      end
      if (state_nxt == LOW && state != LOW) begin
        tx   <= {tx[6:0], 1'b0};
        bits <= bits + 4'd1;
      end
      if (state_nxt == DONE) begin
        rx_out <= rx;
      end
    end
  end

  assign s_clk         = (state == HIGH);
  assign mosi          = tx[7];
  assign host.busy     = (state != IDLE);
  assign host.done     = (state == DONE);
  assign host.data_out = rx_out;

  always_comb begin
    slave_sel = 1'b0;
    case (state)
      IDLE:    slave_sel = 1'b1;
      DONE:    slave_sel = !take;
      default: slave_sel = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: D=4 instance with a model slave,
// D=1 instance in loopback.
module tb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_master_if h4 ();
  spi_master_if h1 ();

  logic miso4, sclk4, mosi4, ss4;
  logic sclk1, mosi1, ss1;

  spi_master #(.CLK_DIV(4)) u4 (
    .clk       (clk),
    .reset     (reset),
    .host      (h4.slave),
    .miso      (miso4),
    .s_clk     (sclk4),
    .mosi      (mosi4),
    .slave_sel (ss4)
  );

  spi_master #(.CLK_DIV(1)) u1 (
    .clk       (clk),
    .reset     (reset),
    .host      (h1.slave),
    .miso      (mosi1),
    .s_clk     (sclk1),
    .mosi      (mosi1),
    .slave_sel (ss1)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         at;
  } exp_t;

  exp_t       sb4[$];
  exp_t       sb1[$];
  logic [7:0] sq[$];
  int         vec = 0;
  int         errs = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model SPI slave: returns a queued byte MSB first, records mosi at rises.
  logic [7:0] sreg = 8'd0;
  logic [7:0] cap = 8'd0;
  logic [7:0] mosi_byte = 8'd0;
  int         k = 0;

  assign miso4 = sreg[7];

  always @(negedge ss4) begin
    k = 0;
    if (sq.size() > 0) sreg = sq.pop_front();
  end

  always @(posedge sclk4) begin
    cap = {cap[6:0], mosi4};
    k++;
    if (k == 8) begin
      mosi_byte = cap;
      k = 0;
    end
  end

  always @(negedge sclk4) begin
    sreg = sreg << 1;
    if (k == 0 && sq.size() > 0) sreg = sq.pop_front();
  end

  logic p4 = 1'b0;
  int   r4 = 0;
  exp_t e4;

  always @(negedge clk) begin
    if (!reset) r4 = 0;
    else if (sclk4 && !p4) r4++;
    p4 = sclk4;
    if (h4.done) begin
      if (sb4.size() == 0) begin
        chk("unexpected_done4", {31'd0, h4.done}, 32'd0);
      end else begin
        e4 = sb4.pop_front();
        chk("data_out4", {24'd0, h4.data_out}, {24'd0, e4.rx});
        chk("done_cycle4", cyc, e4.at);
        chk("mosi_byte4", {24'd0, mosi_byte}, {24'd0, e4.tx});
        chk("sclk_rises4", r4, 8);
        if (!h4.start) chk("ss_in_done4", {31'd0, ss4}, 32'd1);
      end
      r4 = 0;
    end
  end

  exp_t e1;

  always @(negedge clk) begin
    if (h1.done) begin
      if (sb1.size() == 0) begin
        chk("unexpected_done1", {31'd0, h1.done}, 32'd0);
      end else begin
        e1 = sb1.pop_front();
        chk("data_out1", {24'd0, h1.data_out}, {24'd0, e1.rx});
        chk("done_cycle1", cyc, e1.at);
      end
    end
  end

  task automatic issue4(input logic [7:0] tx, input logic [7:0] rx);
    sq.push_back(rx);
    sb4.push_back('{tx, rx, cyc + 1 + 17 * 4});
    h4.data_in = tx;
    h4.start = 1'b1;
    tick(1);
    h4.start = 1'b0;
  endtask

  task automatic issue1(input logic [7:0] tx);
    sb1.push_back('{tx, tx, cyc + 1 + 17 * 1});
    h1.data_in = tx;
    h1.start = 1'b1;
    tick(1);
    h1.start = 1'b0;
  endtask

  task automatic wait4();
    int n = 0;
    while ((sb4.size() > 0 || h4.busy) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      vec++;
      errs++;
      $display("FAIL timeout4: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic wait1();
    int n = 0;
    while ((sb1.size() > 0 || h1.busy) && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      vec++;
      errs++;
      $display("FAIL timeout1: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] a, b;
    logic ss_ok;

    h4.start = 1'b1;
    h4.data_in = 8'hC3;
    h1.start = 1'b0;
    h1.data_in = 8'h00;
    reset = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ss", {31'd0, ss4}, 32'd1);
      chk("rst_sclk", {31'd0, sclk4}, 32'd0);
      chk("rst_busy", {31'd0, h4.busy}, 32'd0);
      chk("rst_done", {31'd0, h4.done}, 32'd0);
      chk("rst_dout", {24'd0, h4.data_out}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    h4.start = 1'b0;
    tick(10);
    chk("post_rst_busy", {31'd0, h4.busy}, 32'd0);
    chk("post_rst_ss", {31'd0, ss4}, 32'd1);

    issue4(8'hA5, 8'h3C);
    wait4();

    repeat (20) begin
      a = 8'($urandom);
      b = 8'($urandom);
      issue4(a, b);
      wait4();
      tick($urandom_range(0, 3));
    end

    // start with new data mid-transfer must be ignored
    c0 = cyc;
    issue4(8'h81, 8'($urandom));
    tick(19);
    h4.data_in = 8'h7E;
    h4.start = 1'b1;
    tick(1);
    h4.start = 1'b0;
    h4.data_in = 8'h00;
    wait4();
    tick(5);

    // abort with reset at cycle 30 of a transfer
    c0 = cyc;
    issue4(8'($urandom), 8'($urandom));
    tick(29);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    chk("abort_ss", {31'd0, ss4}, 32'd1);
    chk("abort_sclk", {31'd0, sclk4}, 32'd0);
    chk("abort_done", {31'd0, h4.done}, 32'd0);
    reset = 1'b1;
    sb4.delete();
    sq.delete();
    tick(2);
    issue4(8'h55, 8'($urandom));
    wait4();
    tick(2);

    issue1(8'hFF);
    wait1();
    issue1(8'h00);
    wait1();
    repeat (6) begin
      issue1(8'($urandom));
      wait1();
      tick($urandom_range(0, 2));
    end

`ifdef SPI_MASTER_BURST_EN
    tick(2);
    c0 = cyc;
    a = 8'($urandom);
    b = 8'($urandom);
    sq.push_back(a);
    sq.push_back(b);
    sb4.push_back('{8'h12, a, c0 + 69});
    h4.data_in = 8'h12;
    h4.start = 1'b1;
    tick(1);
    h4.start = 1'b0;
    ss_ok = 1'b1;
    repeat (68) begin
      if (ss4 !== 1'b0) ss_ok = 1'b0;
      tick(1);
    end
    sb4.push_back('{8'h34, b, c0 + 69 + 69});
    h4.data_in = 8'h34;
    h4.start = 1'b1;
    #1;
    if (ss4 !== 1'b0) ss_ok = 1'b0;
    tick(1);
    h4.start = 1'b0;
    repeat (68) begin
      if (ss4 !== 1'b0) ss_ok = 1'b0;
      tick(1);
    end
    chk("burst_ss_low", {31'd0, ss_ok}, 32'd1);
    wait4();
`else
    ss_ok = 1'b1;
`endif

    tick(3);
    chk("sb_empty", sb4.size() + sb1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
